log_mag_frame_sequencer: RTL and testbench

Frame-level controller for the 3-stage log-magnitude pipeline (x²+y² → MSB-normalise → log LUT). It accepts one frame of N_BINS complex FFT bins over a valid/ready stream and drives the pipeline's global advance enable (calc_ready). It tracks in-flight bins with a valid/index shadow pipeline and presents tagged log-magnitude results to the spectrum display buffer with backpressure. It sits between the FFT output buffer and the display frame buffer, and signals frame done.

---
 rtl/log_mag_pkg.sv | 18 +
 rtl/log_mag_shadow_pipe.sv | 40 ++++
 rtl/log_mag_frame_sequencer.sv | 111 +++++++++++
 tb/tb_log_mag_frame_sequencer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/log_mag_pkg.sv
// Shared constants and FSM encoding for the log-magnitude frame sequencer and its shadow pipeline.
// Sample/log widths are fixed by the external x^2+y^2 -> normalise -> LUT pipeline.
package log_mag_pkg;

    localparam int PIPE_LAT   = 3;
    localparam int N_BINS_DEF = 256;
    localparam int IDX_W_DEF  = 8;
    localparam int SAMPLE_W   = 16;
    localparam int LOG_W      = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } seq_state_t;

endpackage

// File: rtl/log_mag_shadow_pipe.sv
// Valid+index shadow of the log-magnitude pipeline; DEPTH stages, shifts only when en is high.
// Latency DEPTH enabled cycles; holds contents while en is low so tags stay aligned with the datapath.
module log_mag_shadow_pipe
    import log_mag_pkg::*;
#(
    parameter int DEPTH = PIPE_LAT,
    parameter int IDX_W = IDX_W_DEF
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             en,
    input  logic             head_valid,
    input  logic [IDX_W-1:0] head_idx,
    output logic             tail_valid,
    output logic [IDX_W-1:0] tail_idx
);

    logic [DEPTH-1:0] vld;
    logic [IDX_W-1:0] idx [DEPTH];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            vld <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                idx[i] <= '0;
            end
        end else if (en) begin
            vld[0] <= head_valid;
            idx[0] <= head_idx;
            for (int i = 1; i < DEPTH; i++) begin
                vld[i] <= vld[i-1];
                idx[i] <= idx[i-1];
            end
        end
    end

    assign tail_valid = vld[DEPTH-1];
    assign tail_idx   = idx[DEPTH-1];

endmodule

// File: rtl/log_mag_frame_sequencer.sv
// Frame controller for the 3-stage log-magnitude pipeline: feeds N_BINS bins, tags results, pulses done.
// Result appears PIPE_LAT advances after accept; a stalled output freezes the whole pipeline and the input.
module log_mag_frame_sequencer
    import log_mag_pkg::*;
#(
    parameter int N_BINS = N_BINS_DEF,
    parameter int IDX_W  = IDX_W_DEF
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    input  logic                       bin_valid,
    output logic                       bin_ready,
    input  logic signed [SAMPLE_W-1:0] bin_x,
    input  logic signed [SAMPLE_W-1:0] bin_y,
    output logic                       calc_ready,
    output logic signed [SAMPLE_W-1:0] calc_x,
    output logic signed [SAMPLE_W-1:0] calc_y,
    input  logic [LOG_W-1:0]           calc_log_mag,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [LOG_W-1:0]           out_data,
    output logic [IDX_W-1:0]           out_idx
);

    localparam logic [IDX_W:0] FRAME_LEN = N_BINS[IDX_W:0];
    localparam logic [IDX_W:0] LAST_CNT  = FRAME_LEN - 1'b1;
    localparam logic [IDX_W:0] CNT_ONE   = 1;

    seq_state_t     state;
    logic [IDX_W:0] in_cnt;
    logic [IDX_W:0] out_cnt;
    logic           adv;
    logic           accept;
    logic           out_fire;

    // One global advance: the pipeline, shadow tags and input all move together or not at all.
    assign adv        = busy && (!out_valid || out_ready);
    assign calc_ready = adv;
    assign bin_ready  = adv && (state == ST_RUN) && (in_cnt < FRAME_LEN);
    assign accept     = bin_valid && bin_ready;
    assign out_fire   = out_valid && out_ready;

    assign calc_x   = accept ? bin_x : '0;
    assign calc_y   = accept ? bin_y : '0;
    assign out_data = calc_log_mag;

    log_mag_shadow_pipe #(
        .DEPTH (PIPE_LAT),
        .IDX_W (IDX_W)
    ) u_shadow (
        .clk        (clk),
        .resetn     (resetn),
        .en         (adv),
        .head_valid (accept),
        .head_idx   (in_cnt[IDX_W-1:0]),
        .tail_valid (out_valid),
        .tail_idx   (out_idx)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            in_cnt  <= '0;
            out_cnt <= '0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                in_cnt <= in_cnt + CNT_ONE;
            end
            if (out_fire) begin
                out_cnt <= out_cnt + CNT_ONE;
            end
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state   <= ST_RUN;
                        busy    <= 1'b1;
                        in_cnt  <= '0;
                        out_cnt <= '0;
                    end
                end
                ST_RUN: begin
                    if (accept && (in_cnt == LAST_CNT)) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // The final result can only leave after the last accept, so this is the sole exit.
                    if (out_fire && (out_cnt == LAST_CNT)) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_log_mag_frame_sequencer.sv
// Directed bench for log_mag_frame_sequencer with a behavioural model of the external 3-stage pipeline.
module tb_log_mag_frame_sequencer;

    localparam int N_BINS = 256;
    localparam int IDX_W  = 8;

    logic              clk = 1'b0;
    logic              resetn;
    logic              start;
    logic              busy;
    logic              done;
    logic              bin_valid;
    logic              bin_ready;
    logic signed [15:0] bin_x;
    logic signed [15:0] bin_y;
    logic              calc_ready;
    logic signed [15:0] calc_x;
    logic signed [15:0] calc_y;
    logic [7:0]        calc_log_mag;
    logic              out_valid;
    logic              out_ready;
    logic [7:0]        out_data;
    logic [IDX_W-1:0]  out_idx;

    int checks   = 0;
    int failures = 0;
    int sent     = 0;
    int exp_idx  = 0;
    int cyc_n    = 0;
    int done_cnt = 0;
    int t_first  = 0;
    int t_last   = 0;
    int t_done   = 0;
    int seen     = 0;
    logic [9:0] pat;

    always #5 clk = ~clk;

    log_mag_frame_sequencer #(
        .N_BINS (N_BINS),
        .IDX_W  (IDX_W)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .bin_valid    (bin_valid),
        .bin_ready    (bin_ready),
        .bin_x        (bin_x),
        .bin_y        (bin_y),
        .calc_ready   (calc_ready),
        .calc_x       (calc_x),
        .calc_y       (calc_y),
        .calc_log_mag (calc_log_mag),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_idx      (out_idx)
    );

    function automatic logic [31:0] mag2(input logic signed [15:0] x, input logic signed [15:0] y);
        longint a;
        longint b;
        a = x;
        b = y;
        return 32'(a * a + b * b);
    endfunction

    // Log LUT model: {msb position, three bits below the msb}; zero maps to zero.
    function automatic logic [7:0] lut(input logic [31:0] v);
        int msb;
        logic [31:0] n;
        msb = -1;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) msb = i;
        end
        if (msb < 0) return 8'd0;
        n = v << (31 - msb);
        return {msb[4:0], n[30:28]};
    endfunction

    function automatic logic signed [15:0] gen_x(input int i);
        if (i == 0) return 16'sd3;
        if (i == 1) return -16'sd32768;
        if (i == 2) return 16'sd0;
        return 16'(i * 37 - 3000);
    endfunction

    function automatic logic signed [15:0] gen_y(input int i);
        if (i == 0) return 16'sd4;
        if (i == 1) return -16'sd32768;
        if (i == 2) return 16'sd0;
        return 16'(1000 - i * 11);
    endfunction

    // External pipeline: x^2+y^2, normalise (carried as the raw value), LUT.
    logic [31:0] p1;
    logic [31:0] p2;
    logic [7:0]  p3;
    always @(posedge clk) begin
        if (!resetn) begin
            p1 <= '0;
            p2 <= '0;
            p3 <= '0;
        end else if (calc_ready) begin
            p1 <= mag2(calc_x, calc_y);
            p2 <= p1;
            p3 <= lut(p2);
        end
    end
    assign calc_log_mag = p3;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        assert (got === want) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, want);
        end
    endtask

    // One clock: record handshakes just before the edge, refresh source data after it, return past negedge.
    task automatic cyc();
        #1;
        if (bin_valid === 1'b1 && bin_ready === 1'b1) sent++;
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            chk("sb_idx", 64'(out_idx), 64'(exp_idx));
            chk("sb_data", 64'(out_data), 64'(lut(mag2(gen_x(exp_idx), gen_y(exp_idx)))));
            if (exp_idx == 0) t_first = cyc_n;
            if (exp_idx == N_BINS - 1) t_last = cyc_n;
            exp_idx++;
        end
        @(posedge clk);
        #1;
        bin_x = gen_x(sent);
        bin_y = gen_y(sent);
        @(negedge clk);
        #1;
        cyc_n++;
        if (done === 1'b1) done_cnt++;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_bin_ready"}, 64'(bin_ready), 64'd0);
        chk({tag, "_calc_ready"}, 64'(calc_ready), 64'd0);
        chk({tag, "_calc_x"}, 64'(calc_x), 64'd0);
        chk({tag, "_calc_y"}, 64'(calc_y), 64'd0);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_out_idx"}, 64'(out_idx), 64'd0);
        chk({tag, "_out_data"}, 64'(out_data), 64'd0);
    endtask

    initial begin
        resetn    = 1'b0;
        start     = 1'b1;
        bin_valid = 1'b1;
        out_ready = 1'b1;
        bin_x     = 16'sd5;
        bin_y     = 16'sd7;
        @(negedge clk);
        #1;

        // Reset with start and bin_valid asserted: everything zero.
        cyc();
        cyc();
        chk_all_zero("reset");

        // Start seen only while reset was low must not launch a frame.
        resetn = 1'b1;
        start  = 1'b0;
        cyc();
        chk("start_in_reset_busy", 64'(busy), 64'd0);
        chk("start_in_reset_bin_ready", 64'(bin_ready), 64'd0);

        // Latency frame.
        sent    = 0;
        exp_idx = 0;
        bin_x   = gen_x(0);
        bin_y   = gen_y(0);
        start   = 1'b1;
        cyc();
        start = 1'b0;
        #1;
        chk("run_busy", 64'(busy), 64'd1);
        chk("run_bin_ready", 64'(bin_ready), 64'd1);
        chk("run_calc_ready", 64'(calc_ready), 64'd1);
        chk("run_calc_x", 64'(calc_x), 64'(16'sd3));
        chk("run_calc_y", 64'(calc_y), 64'(16'sd4));
        cyc();
        chk("lat_e0_out_valid", 64'(out_valid), 64'd0);
        cyc();
        chk("lat_e1_out_valid", 64'(out_valid), 64'd0);
        cyc();
        chk("lat_e2_out_valid", 64'(out_valid), 64'd1);
        chk("lat_out_idx", 64'(out_idx), 64'd0);
        chk("lat_out_data_25", 64'(out_data), 64'd36);
        cyc();
        chk("ext_idx1", 64'(out_idx), 64'd1);
        chk("ext_data_2p31", 64'(out_data), 64'd248);
        cyc();
        chk("ext_idx2", 64'(out_idx), 64'd2);
        chk("ext_data_zero", 64'(out_data), 64'd0);

        // Start pulse during RUN is ignored; the scoreboard would catch an index restart.
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("start_in_run_busy", 64'(busy), 64'd1);
        cyc();
        cyc();

        // Output backpressure for five cycles.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_out_idx", 64'(out_idx), 64'(exp_idx));
            chk("bp_out_data", 64'(out_data), 64'(lut(mag2(gen_x(exp_idx), gen_y(exp_idx)))));
            chk("bp_bin_ready", 64'(bin_ready), 64'd0);
            chk("bp_calc_ready", 64'(calc_ready), 64'd0);
        end
        out_ready = 1'b1;
        cyc();
        cyc();
        cyc();

        // Source starvation: out_valid follows the accept pattern three advance edges later.
        pat = 10'b1001101111;
        for (int k = 0; k < 10; k++) begin
            bin_valid = pat[9-k];
            #1;
            chk("starve_bin_ready", 64'(bin_ready), 64'd1);
            if (pat[9-k]) begin
                chk("starve_calc_x", 64'(calc_x), 64'(gen_x(sent)));
            end else begin
                chk("starve_bubble_x", 64'(calc_x), 64'd0);
                chk("starve_bubble_y", 64'(calc_y), 64'd0);
            end
            if (k >= 3) chk("starve_out_valid", 64'(out_valid), 64'(pat[9-(k-3)]));
            cyc();
        end
        bin_valid = 1'b1;

        // Stream up to bin 100, then reset mid-frame.
        for (int i = 0; i < 400 && sent < 100; i++) cyc();
        chk("reach_bin_100", 64'(sent), 64'd100);
        resetn = 1'b0;
        cyc();
        chk_all_zero("midreset");
        resetn  = 1'b1;
        sent    = 0;
        exp_idx = 0;
        bin_x   = gen_x(0);
        bin_y   = gen_y(0);
        cyc();
        chk("after_reset_busy", 64'(busy), 64'd0);
        chk("no_done_on_abort", 64'(done_cnt), 64'd0);

        // Full frame, continuous streaming.
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int i = 0; i < 600 && seen == 0; i++) begin
            cyc();
            if (done === 1'b1) begin
                seen   = 1;
                t_done = cyc_n;
            end
        end
        chk("done_seen", 64'(seen), 64'd1);
        chk("results_count", 64'(exp_idx), 64'd256);
        chk("no_gaps", 64'(t_last - t_first), 64'd255);
        chk("done_timing", 64'(t_done), 64'(t_last + 1));
        cyc();
        chk("post_done_done", 64'(done), 64'd0);
        chk("post_done_busy", 64'(busy), 64'd0);
        chk("post_done_out_valid", 64'(out_valid), 64'd0);
        chk("post_done_bin_ready", 64'(bin_ready), 64'd0);
        cyc();
        cyc();
        chk("done_pulse_count", 64'(done_cnt), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
